// File: rtl/j1_io_responder.sv
// I/O-window responder for the j1 data bus: UART-TX with a byte FIFO, GPIO and a
// free-running tick counter, all decoded inside 0xF000-0xF00F.
module j1_io_responder #(
  parameter int          CLKS_PER_BIT = 217,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [15:0] GPIO_RESET   = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_wr,
  input  logic [15:0] dout,
  output logic [15:0] din,
  output logic        io_sel,
  output logic        uart_tx,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  tx_state_t       state;
  logic [7:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [TW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [15:0]     ticks;
  logic [15:0]     sync1, sync2;
  logic            ovf;

  logic [2:0] idx;
  logic       wr, full, busy, pop, push_req, push_ok, bit_end, unused_addr_lsb;

  assign io_sel          = (mem_addr[15:4] == 12'hF00);
  assign idx             = mem_addr[3:1];
  assign unused_addr_lsb = mem_addr[0];
  assign wr              = mem_wr & io_sel;
  assign full            = (count == CW'(FIFO_DEPTH));
  assign busy            = (count != '0) | (state != IDLE);
  assign bit_end         = (clk_cnt == TW'(CLKS_PER_BIT - 1));
  // The serializer takes the head byte when idle, or at the last clock of a stop bit.
  assign pop             = (count != '0) & ((state == IDLE) | ((state == STOP) & bit_end));
  assign push_req        = wr & (idx == 3'd0);
  assign push_ok         = push_req & (~full | pop);

  always_comb begin
    din = 16'h0000;
    if (io_sel) begin
      case (idx)
        3'd1:    din = {13'b0, ovf, full, busy};
        3'd2:    din = gpio_out;
        3'd3:    din = sync2;
        3'd4:    din = ticks;
        default: din = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= GPIO_RESET;
      ticks    <= 16'h0000;
      sync1    <= 16'h0000;
      sync2    <= 16'h0000;
      ovf      <= 1'b0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr && idx == 3'd2) gpio_out <= dout;
      if (wr && idx == 3'd4) ticks <= dout;
      else                   ticks <= ticks + 16'd1;
      // A dropped push outranks a clear arriving in the same cycle.
      if (push_req && !push_ok)   ovf <= 1'b1;
      else if (wr && idx == 3'd1) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= dout[7:0];
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (!push_ok && pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      uart_tx <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= 3'd0;
      shift   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            clk_cnt <= '0;
            uart_tx <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            uart_tx <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            state   <= DATA;
          end else clk_cnt <= clk_cnt + TW'(1);
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else clk_cnt <= clk_cnt + TW'(1);
        end
        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (pop) begin
              shift   <= fifo_mem[rd_ptr];
              uart_tx <= 1'b0;
              state   <= START;
            end else state <= IDLE;
          end else clk_cnt <= clk_cnt + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_j1_io_responder.sv
// Directed-vector bench for j1_io_responder with a short UART bit time (4 clks).
module tb_j1_io_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_wr;
  logic [15:0] dout;
  logic [15:0] din;
  logic        io_sel;
  logic        uart_tx;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;

  int vectors = 0;
  int miscompares = 0;

  j1_io_responder #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8), .GPIO_RESET(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wr(mem_wr), .dout(dout),
    .din(din), .io_sel(io_sel), .uart_tx(uart_tx), .gpio_in(gpio_in), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] addr, input logic wr, input logic [15:0] data);
    mem_addr = addr;
    mem_wr   = wr;
    dout     = data;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One store strobe; returns 1 time unit after the edge that performed it.
  task automatic writeIo(input logic [15:0] addr, input logic [15:0] data);
    mem_addr = addr;
    mem_wr   = 1'b1;
    dout     = data;
    @(posedge clk);
    #1;
    mem_wr = 1'b0;
  endtask

  task automatic readCheck(input string tag, input logic [15:0] addr, input logic [15:0] expected);
    applyStimulus(addr, 1'b0, 16'h0000);
    checkOutput(tag, din, expected);
  endtask

  initial begin
    logic [9:0] frame;
    logic [7:0] second;
    int         waited;
    reset = 1'b1;
    gpio_in = 16'h0000;
    applyStimulus(16'h0000, 1'b0, 16'h0000);
    tick(2);
    reset = 1'b0;

    // Reset state
    checkOutput("rst_tx", {15'b0, uart_tx}, 16'h0001);
    checkOutput("rst_gpio", gpio_out, 16'h0000);
    readCheck("rst_stat", 16'hF002, 16'h0000);
    checkOutput("rst_iosel", {15'b0, io_sel}, 16'h0001);

    // Single frame of 0x41: start, 1000 0010 (LSB first), stop
    writeIo(16'hF000, 16'h0141);
    readCheck("t1_busy", 16'hF002, 16'h0001);
    checkOutput("t1_tx_idle", {15'b0, uart_tx}, 16'h0001);
    tick(1);
    frame = 10'b1_0100_0001_0;
    for (int k = 0; k < 10; k++) begin
      tick(2);
      checkOutput($sformatf("t1_bit%0d", k), {15'b0, uart_tx}, {15'b0, frame[k]});
      tick(2);
    end
    readCheck("t1_done", 16'hF002, 16'h0000);

    // Two frames back-to-back: stop of the first runs straight into the start of the second
    writeIo(16'hF000, 16'h0055);
    writeIo(16'hF000, 16'h00F0);
    tick(39);
    checkOutput("t5_stop1", {15'b0, uart_tx}, 16'h0001);
    tick(1);
    checkOutput("t5_start2", {15'b0, uart_tx}, 16'h0000);
    readCheck("t5_busy", 16'hF002, 16'h0001);
    second = 8'hF0;
    tick(5);
    checkOutput("t5_d0", {15'b0, uart_tx}, {15'b0, second[0]});
    tick(16);
    checkOutput("t5_d4", {15'b0, uart_tx}, {15'b0, second[4]});
    tick(19);
    readCheck("t5_done", 16'hF002, 16'h0000);

    // Overflow: one byte goes to the serializer, eight fill the FIFO, the tenth is dropped
    for (int i = 0; i < 9; i++) writeIo(16'hF000, 16'(i));
    readCheck("t2_full", 16'hF002, 16'h0003);
    writeIo(16'hF000, 16'h00EE);
    readCheck("t2_ovf", 16'hF002, 16'h0007);
    writeIo(16'hF002, 16'h0000);
    readCheck("t2_clr", 16'hF002, 16'h0003);
    waited = 0;
    while (din !== 16'h0000 && waited < 500) begin
      tick(1);
      waited++;
    end
    checkOutput("t2_drain", 16'(waited < 500), 16'h0001);
    checkOutput("t2_tx_idle", {15'b0, uart_tx}, 16'h0001);

    // Tick counter load and wrap
    writeIo(16'hF008, 16'h1234);
    readCheck("t3_load", 16'hF008, 16'h1234);
    tick(1);
    checkOutput("t3_inc", din, 16'h1235);
    writeIo(16'hF008, 16'hFFFF);
    readCheck("t3_ffff", 16'hF008, 16'hFFFF);
    tick(1);
    checkOutput("t3_wrap", din, 16'h0000);
    tick(1);
    checkOutput("t3_after", din, 16'h0001);

    // GPIO output, synchronized input, aliasing and out-of-window access
    writeIo(16'hF004, 16'hA5A5);
    checkOutput("t4_gpo", gpio_out, 16'hA5A5);
    readCheck("t4_gpo_rd", 16'hF004, 16'hA5A5);
    readCheck("t4_odd_alias", 16'hF005, 16'hA5A5);
    writeIo(16'h1004, 16'h1111);
    checkOutput("t4_outside_wr", gpio_out, 16'hA5A5);
    gpio_in = 16'h00FF;
    readCheck("t4_gpi_0", 16'hF006, 16'h0000);
    tick(1);
    checkOutput("t4_gpi_1", din, 16'h0000);
    tick(1);
    checkOutput("t4_gpi_2", din, 16'h00FF);
    readCheck("t4_unmapped", 16'hF00A, 16'h0000);
    readCheck("t4_uart_data", 16'hF000, 16'h0000);
    readCheck("t4_ram_din", 16'h1000, 16'h0000);
    checkOutput("t4_ram_iosel", {15'b0, io_sel}, 16'h0000);

    // Reset in the middle of data bit 3 aborts the frame and flushes the queue
    writeIo(16'hF000, 16'h0000);
    writeIo(16'hF000, 16'h0000);
    tick(17);
    checkOutput("t6_mid_bit3", {15'b0, uart_tx}, 16'h0000);
    reset = 1'b1;
    tick(1);
    checkOutput("t6_rst_tx", {15'b0, uart_tx}, 16'h0001);
    checkOutput("t6_rst_gpio", gpio_out, 16'h0000);
    readCheck("t6_rst_stat", 16'hF002, 16'h0000);
    reset = 1'b0;
    tick(6);
    checkOutput("t6_post_tx", {15'b0, uart_tx}, 16'h0001);
    readCheck("t6_post_stat", 16'hF002, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
